// File: rtl/stochastic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stochastic_pkg : shared widths and state encoding for stochastic path |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package stochastic_pkg;

  localparam int WIDTH_DEF  = 10;
  localparam int WINDOW_DEF = (1 << WIDTH_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sng_state_t;

endpackage
`default_nettype wire

// File: rtl/sng_window_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sng_window_if : control, random-word and result bundle for sng_window |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface sng_window_if
  import stochastic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;
  logic             sbit;
  logic             sbit_valid;
  logic [WIDTH-1:0] count;
  logic             done;

  modport master (
    output start, abort, value, lfsr_in,
    input  busy, sbit, sbit_valid, count, done
  );

  modport slave (
    input  start, abort, value, lfsr_in,
    output busy, sbit, sbit_valid, count, done
  );

endinterface
`default_nettype wire

// File: rtl/sng_cmp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sng_cmp : unsigned lfsr_in <= value_q comparator (one stochastic bit) |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module sng_cmp
  import stochastic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic [WIDTH-1:0] value_q,
  output logic             bit_out
);

  assign bit_out = (lfsr_in <= value_q);

endmodule
`default_nettype wire

// File: rtl/sng_window.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sng_window : stochastic number generator over one LFSR-period window  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module sng_window
  import stochastic_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sng_window_if.slave   bus
);

  localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(WINDOW - 1);

  sng_state_t       state, state_nxt;
  logic [WIDTH-1:0] value_q, value_nxt;
  logic [WIDTH-1:0] cyc_cnt, cyc_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             sbit_q, sbit_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;
  logic             cmp_bit;

  sng_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .lfsr_in (bus.lfsr_in),
    .value_q (value_q),
    .bit_out (cmp_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      value_q <= '0;
      cyc_cnt <= '0;
      acc     <= '0;
      count_q <= '0;
      sbit_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      value_q <= value_nxt;
      cyc_cnt <= cyc_nxt;
      acc     <= acc_nxt;
      count_q <= count_nxt;
      sbit_q  <= sbit_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    value_nxt = value_q;
    cyc_nxt   = cyc_cnt;
    acc_nxt   = acc;
    count_nxt = count_q;
    sbit_nxt  = 1'b0;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          value_nxt = bus.value;
          cyc_nxt   = '0;
          acc_nxt   = '0;
        end
      end
      ST_RUN: begin
        // Abort wins over completion and discards the partial accumulation.
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else begin
          sbit_nxt  = cmp_bit;
          valid_nxt = 1'b1;
          acc_nxt   = acc + WIDTH'(cmp_bit);
          cyc_nxt   = cyc_cnt + WIDTH'(1);
          if (cyc_cnt == LAST_CYC) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        count_nxt = acc;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.busy       = (state == ST_RUN);
  assign bus.sbit       = sbit_q;
  assign bus.sbit_valid = valid_q;
  assign bus.count      = count_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sng_window.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sng_window : randomized scoreboard bench for sng_window            |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_sng_window;
  import stochastic_pkg::*;

  localparam int           W         = 10;
  localparam int           WIN       = 1023;
  localparam logic [W-1:0] SEED      = 10'b1100000000;
  localparam logic [W-1:0] LFSR_MASK = 10'h240;   // x^10 + x^7 + 1, Galois form
  localparam int           M_IDLE    = 0;
  localparam int           M_RUN     = 1;
  localparam int           M_FIN     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sng_window_if #(.WIDTH(W)) bus ();

  sng_window #(
    .WIDTH  (W),
    .WINDOW (WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   expq[$];
  logic rst_seen = 1'b0;

  logic [W-1:0] lfsr = SEED;
  assign bus.lfsr_in = lfsr;

  always @(negedge clk) begin
    lfsr = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  end

  always @(posedge rst) rst_seen = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a window samples WIN consecutive words of a maximal LFSR, so
  // exactly `value` of them satisfy word <= value and the count equals value.
  task automatic start_window(input int v);
    bus.start = 1'b1;
    bus.value = W'(v);
    expq.push_back(v);
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = W'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check({name, " done seen"}, int'(bus.done), 1);
  endtask

  // Monitor: cycle-level expectations derived from the inputs seen at each edge.
  int           mode       = M_IDLE;
  int           taken      = 0;
  int           last_count = 0;
  int           cur_exp    = 0;
  int           obs_ones   = 0;
  logic [W-1:0] mv         = '0;
  logic         e_sbit, e_valid, e_done;
  logic         s_start, s_abort;
  logic [W-1:0] s_value, s_lfsr;

  always @(posedge clk) begin
    s_start = bus.start;
    s_abort = bus.abort;
    s_value = bus.value;
    s_lfsr  = bus.lfsr_in;
    e_sbit  = 1'b0;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (rst || rst_seen) begin
      rst_seen   = 1'b0;
      mode       = M_IDLE;
      last_count = 0;
      expq.delete();
    end
    if (!rst) begin
      if (mode == M_IDLE) begin
        if (s_start) begin
          mode     = M_RUN;
          mv       = s_value;
          taken    = 0;
          obs_ones = 0;
        end
      end else if (mode == M_RUN) begin
        if (s_abort) begin
          mode = M_IDLE;
          if (expq.size() > 0) void'(expq.pop_front());
        end else begin
          e_sbit  = (s_lfsr <= mv);
          e_valid = 1'b1;
          taken++;
          if (taken == WIN) mode = M_FIN;
        end
      end else begin
        e_done     = 1'b1;
        mode       = M_IDLE;
        cur_exp    = (expq.size() > 0) ? expq.pop_front() : -1;
        last_count = cur_exp;
      end
    end
    #1;
    check("busy", int'(bus.busy), int'(mode == M_RUN));
    check("sbit_valid", int'(bus.sbit_valid), int'(e_valid));
    check("sbit", int'(bus.sbit), int'(e_sbit));
    check("done", int'(bus.done), int'(e_done));
    check("count", int'(bus.count), last_count);
    if (bus.sbit_valid && bus.sbit) obs_ones++;
    if (e_done) check("ones observed", obs_ones, cur_exp);
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_window(512);
    wait_done("w512");

    start_window(0);
    wait_done("w0");
    start_window(1023);
    wait_done("w1023");

    // Re-start and value change mid-window must be ignored.
    @(negedge clk);
    start_window(300);
    repeat (98) @(negedge clk);
    bus.start = 1'b1;
    bus.value = W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("w300");

    // Abort mid-window, then abort while idle.
    @(negedge clk);
    start_window(700);
    repeat (398) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    repeat (2) @(negedge clk);
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of a clock period.
    start_window(700);
    repeat (598) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst busy", int'(bus.busy), 0);
    check("rst sbit", int'(bus.sbit), 0);
    check("rst sbit_valid", int'(bus.sbit_valid), 0);
    check("rst done", int'(bus.done), 0);
    check("rst count", int'(bus.count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_window(1);
    wait_done("w1");

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      start_window(int'($urandom_range(0, 1023)));
      wait_done("wrand");
    end

    repeat (3) @(negedge clk);
    check("queue drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
